// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: watches the gated domain for idleness, handshakes a
// sleep request, drives the clock-gate cell enable and sequences the wake-up.
module clk_gate_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cfg_gate_en,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              sleep_ack,
  input  logic              test_se,
  output logic              clk_en,
  output logic              sleep_req,
  output logic              gated,
  output logic              wake_done
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    COUNT = 3'd1,
    REQ   = 3'd2,
    OFF   = 3'd3,
    WAKE  = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(WAKE_CYC - 1);

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [3:0]        settle_cnt;

  logic wake_cond;
  assign wake_cond = busy || wake_req || !cfg_gate_en;

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values of state and both counters.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= RUN;
      idle_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!wake_cond) begin
            state    <= COUNT;
            idle_cnt <= '0;
          end
        end
        COUNT: begin
          if (wake_cond) begin
            state <= RUN;
          end else begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == idle_thresh) state <= REQ;
          end
        end
        // An abort outranks an acknowledge arriving in the same cycle.
        REQ: begin
          if (busy || wake_req) state <= RUN;
          else if (sleep_ack)   state <= OFF;
        end
        OFF: begin
          if (wake_cond) begin
            state      <= WAKE;
            settle_cnt <= '0;
          end
        end
        WAKE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= RUN;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Pure decodes of flopped state: no extra latency and no combinational
  // path from the functional inputs into the clock-gate enable.
  assign sleep_req = (state == REQ) || (state == OFF);
  assign gated     = (state == OFF);
  assign clk_en    = (state != OFF) || test_se;
  assign wake_done = (state == WAKE) && (settle_cnt == SETTLE_LAST);

endmodule
